pay_station: RTL and testbench

//  Exit-gate payment controller for the parking lot system. It is the producer of the

---
 rtl/pay_station.sv | 110 +++++++++++
 tb/tb_pay_station.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pay_station.sv
// Exit-gate payment controller: collects quarters/dollars against a fixed fee,
// abandons idle sessions, and pays change or refunds as spaced quarter pulses.
module pay_station #(
    parameter int FEE_QTR   = 6,
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Exit_Req,
    input  logic       Coin_25,
    input  logic       Coin_100,
    input  logic       Cancel,
    input  logic       Tick_1,
    output logic       paid_stat,
    output logic       Change_Pulse,
    output logic       Coin_Rej,
    output logic [3:0] Due_Qtr,
    output logic       Busy
);

    typedef enum logic [1:0] {IDLE, COLLECT, PAID, REFUND} state_t;

    localparam logic [4:0] FEE = 5'(FEE_QTR);
    localparam logic [5:0] TMO = 6'(TIMEOUT_S);

    state_t     state, state_next;
    logic [4:0] credit, credit_next, credit_sum;
    logic [4:0] change, change_next;
    logic [5:0] timer, timer_next, timer_upd;
    logic       phase, phase_next;
    logic       pulse_next, rej_next, coin_any;

    always_comb begin
        coin_any    = Coin_25 | Coin_100;
        credit_sum  = credit + {4'b0, Coin_25} + {2'b0, Coin_100, 2'b00};
        timer_upd   = coin_any ? 6'd0 : (Tick_1 ? timer + 6'd1 : timer);
        state_next  = state;
        credit_next = credit;
        change_next = change;
        timer_next  = timer;
        phase_next  = phase;
        pulse_next  = 1'b0;
        rej_next    = 1'b0;
        case (state)
            IDLE: begin
                rej_next = coin_any;
                if (Exit_Req) begin
                    state_next  = COLLECT;
                    credit_next = 5'd0;
                    timer_next  = 6'd0;
                end
            end
            COLLECT: begin
                credit_next = credit_sum;
                timer_next  = timer_upd;
                phase_next  = 1'b0;
                if (Cancel || !Exit_Req) begin
                    state_next  = REFUND;
                    change_next = credit_sum;
                end else if (credit_sum >= FEE) begin
                    state_next  = PAID;
                    change_next = credit_sum - FEE;
                end else if (timer_upd == TMO) begin
                    state_next  = (credit_sum != 5'd0) ? REFUND : IDLE;
                    change_next = credit_sum;
                end
            end
            default: begin
                // PAID and REFUND share the dispenser: one quarter, then one idle cycle
                rej_next = coin_any;
                if (phase) begin
                    phase_next = 1'b0;
                end else if (change != 5'd0) begin
                    pulse_next  = 1'b1;
                    change_next = change - 5'd1;
                    phase_next  = 1'b1;
                end
                if (change == 5'd0 && (state == REFUND || !Exit_Req))
                    state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            credit       <= 5'd0;
            change       <= 5'd0;
            timer        <= 6'd0;
            phase        <= 1'b0;
            paid_stat    <= 1'b0;
            Change_Pulse <= 1'b0;
            Coin_Rej     <= 1'b0;
            Due_Qtr      <= 4'd0;
            Busy         <= 1'b0;
        end else begin
            state        <= state_next;
            credit       <= credit_next;
            change       <= change_next;
            timer        <= timer_next;
            phase        <= phase_next;
            paid_stat    <= (state_next == PAID);
            Change_Pulse <= pulse_next;
            Coin_Rej     <= rej_next;
            Due_Qtr      <= (state_next == COLLECT) ? 4'(FEE - credit_next) : 4'd0;
            Busy         <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_pay_station.sv
// Scoreboard bench for pay_station: a session-level model predicts the outputs
// after every clock edge; a separate monitor compares them against the DUT.
module tb_pay_station;

    localparam int FEE = 6;
    localparam int TMO = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Exit_Req = 1'b0, Coin_25 = 1'b0, Coin_100 = 1'b0, Cancel = 1'b0, Tick_1 = 1'b0;
    logic       paid_stat, Change_Pulse, Coin_Rej, Busy;
    logic [3:0] Due_Qtr;

    pay_station #(.FEE_QTR(FEE), .TIMEOUT_S(TMO)) dut (
        .clk(clk), .reset(reset), .Exit_Req(Exit_Req), .Coin_25(Coin_25),
        .Coin_100(Coin_100), .Cancel(Cancel), .Tick_1(Tick_1),
        .paid_stat(paid_stat), .Change_Pulse(Change_Pulse), .Coin_Rej(Coin_Rej),
        .Due_Qtr(Due_Qtr), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       paid;
        logic       pulse;
        logic       rej;
        logic [3:0] due;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Session model: 0 idle, 1 collecting, 2 paid, 3 refunding.
    // Dispensing is closed-form: entered at edge s with n quarters owed, pulses
    // appear after edges s+1, s+3, ..., s+2n-1 and the dispenser is empty from s+max(2n,1).
    int m_mode = 0, m_credit = 0, m_secs = 0, m_start = 0, m_owed = 0, m_cyc = 0;

    function automatic void start_dispense(input int mode, input int owed);
        m_mode  = mode;
        m_owed  = owed;
        m_start = m_cyc;
    endfunction

    function automatic exp_t model_edge(input logic ex, input logic c25, input logic c100,
                                        input logic can, input logic tick);
        exp_t e;
        int   coins, old_mode, d, done_at;
        e        = '0;
        coins    = int'(c25) + 4 * int'(c100);
        old_mode = m_mode;
        d        = m_cyc - m_start;
        done_at  = (m_owed > 0) ? 2 * m_owed : 1;
        if (old_mode != 1) e.rej = c25 | c100;
        if (old_mode >= 2) e.pulse = (d % 2 == 1) && (d < 2 * m_owed);
        case (old_mode)
            0: if (ex) begin
                m_mode = 1; m_credit = 0; m_secs = 0;
            end
            1: begin
                m_credit += coins;
                if (coins > 0) m_secs = 0;
                else if (tick) m_secs++;
                if (can || !ex) start_dispense(3, m_credit);
                else if (m_credit >= FEE) start_dispense(2, m_credit - FEE);
                else if (m_secs == TMO) begin
                    if (m_credit > 0) start_dispense(3, m_credit);
                    else m_mode = 0;
                end
            end
            default: if (d >= done_at && (old_mode == 3 || !ex)) m_mode = 0;
        endcase
        e.paid = (m_mode == 2);
        e.busy = (m_mode != 0);
        e.due  = (m_mode == 1) ? 4'(FEE - m_credit) : 4'd0;
        m_cyc++;
        return e;
    endfunction

    task automatic cycle(input logic ex, input logic c25, input logic c100,
                         input logic can, input logic tick);
        @(negedge clk);
        Exit_Req = ex; Coin_25 = c25; Coin_100 = c100; Cancel = can; Tick_1 = tick;
        exp_q.push_back(model_edge(ex, c25, c100, can, tick));
    endtask

    task automatic hold(input int n, input logic ex);
        repeat (n) cycle(ex, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        logic [7:0] got;
        got = {paid_stat, Change_Pulse, Coin_Rej, Due_Qtr, Busy};
        n_cmp++;
        if (got !== 8'h00) begin
            n_bad++;
            $display("FAIL %s: outputs=%b required=00000000", name, got);
        end else begin
            $display("%s: outputs all zero ok", name);
        end
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        Exit_Req = 1'b0; Coin_25 = 1'b0; Coin_100 = 1'b0; Cancel = 1'b0; Tick_1 = 1'b0;
        reset = 1'b0;
        #1 check_zero("reset_async");
        repeat (n) begin
            @(negedge clk);
            check_zero("reset_hold");
        end
        reset = 1'b1;
        m_mode = 0; m_credit = 0; m_secs = 0; m_owed = 0;
    endtask

    // Monitor: every edge that has a prediction gets compared
    initial begin
        exp_t e, got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got.paid = paid_stat; got.pulse = Change_Pulse; got.rej = Coin_Rej;
                got.due = Due_Qtr; got.busy = Busy;
                n_cmp++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL outputs t=%0t: got paid=%b pulse=%b rej=%b due=%0d busy=%b required paid=%b pulse=%b rej=%b due=%0d busy=%b",
                             $time, got.paid, got.pulse, got.rej, got.due, got.busy,
                             e.paid, e.pulse, e.rej, e.due, e.busy);
                end else begin
                    $display("t=%0t in ex=%b c25=%b c100=%b can=%b tick=%b -> paid=%b pulse=%b rej=%b due=%0d busy=%b ok",
                             $time, Exit_Req, Coin_25, Coin_100, Cancel, Tick_1,
                             got.paid, got.pulse, got.rej, got.due, got.busy);
                end
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        #1 check_zero("reset_initial");
        @(negedge clk);
        check_zero("reset_initial_hold");
        reset = 1'b1;

        // exact fee in quarters
        hold(1, 1'b1);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(3, 1'b1);
        hold(3, 1'b0);

        // two dollars: 2 quarters change
        hold(1, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(7, 1'b1);
        hold(3, 1'b0);

        // both coins together, then cancel: 5-quarter refund
        hold(1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(12, 1'b1);
        hold(3, 1'b0);

        // timeout with credit, timeout empty, and a coin on the final tick
        hold(1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(3, 1'b0);
        hold(1, 1'b1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b0);
        hold(1, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        hold(2, 1'b1);
        hold(3, 1'b0);

        // rejected coins while idle and while paid
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1, 1'b1);
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        hold(2, 1'b1);
        hold(3, 1'b0);

        // reset in the middle of a 4-quarter refund, then a fresh session
        hold(1, 1'b1);
        repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(2, 1'b1);
        apply_reset(2);
        hold(2, 1'b1);
        hold(3, 1'b0);

        // random traffic: busy coins, then sparse coins to exercise timeouts
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 2) == 0);
        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 29) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 23) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 1) == 0);

        hold(2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending predictions=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
